// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of one shared data memory.
// Define DMEM_ARB_ADDR_CHECK_EN to reject misaligned or out-of-range addresses.
//
// state    | meaning
// ST_IDLE  | waiting for a request; arbitrates and latches the winner's command
// ST_ISSUE | latched command driven to memory; read data captured at the end
// ST_DONE  | ack (and err) to the winner; priority handed to the other port
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  prio;
    logic                  cmd_we;
    logic                  cmd_id;
    logic                  cmd_err;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  any_req;
    logic                  grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  latch_cmd;

    if (MEM_DEPTH < 1) begin : g_depth_check
        $error("dmem_arbiter: MEM_DEPTH must be at least 1");
    end

    // A lone requester always wins; a tie goes to the port holding priority.
    always_comb begin
        any_req   = p0_req | p1_req;
        grant     = (p0_req & p1_req) ? prio : p1_req;
        sel_we    = grant ? p1_we    : p0_we;
        sel_addr  = grant ? p1_addr  : p0_addr;
        sel_wdata = grant ? p1_wdata : p0_wdata;
        latch_cmd = (state == ST_IDLE) & any_req;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prio      <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (latch_cmd) begin
                cmd_we    <= sel_we;
                cmd_id    <= grant;
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
            end
            if ((state == ST_ISSUE) && !cmd_we && !cmd_err) begin
                if (cmd_id) p1_rdata <= mem_rdata;
                else        p0_rdata <= mem_rdata;
            end
            if (state == ST_DONE) prio <= ~cmd_id;
        end
    end

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH) << 2;

    logic sel_err;
    assign sel_err = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (rst)            cmd_err <= 1'b0;
        else if (latch_cmd) cmd_err <= sel_err;
    end
`else
    assign cmd_err = 1'b0;
`endif

    // rst gates the strobe directly so a reset landing in ISSUE never commits a write.
    always_comb begin
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
        mem_w_en  = (state == ST_ISSUE) & cmd_we & ~rst & ~cmd_err;
        p0_ack    = (state == ST_DONE) & ~cmd_id;
        p1_ack    = (state == ST_DONE) &  cmd_id;
        p0_err    = p0_ack & cmd_err;
        p1_err    = p1_ack & cmd_err;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, words in the shared data memory.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: p0_req / p1_req  in  1  each; requester n wants one memory access.
REQ-007 SHALL have ports: p0_we / p1_we  in  1  each; 1 = write, 0 = read.
REQ-008 SHALL have ports: p0_addr / p1_addr  in  ADDR_WIDTH  each; byte address.
REQ-009 SHALL have ports: p0_wdata / p1_wdata  in  DATA_WIDTH  each; write data.
REQ-010 SHALL have ports: p0_ack / p1_ack  out  1  each; one-cycle completion pulse.
REQ-011 SHALL have ports: p0_rdata / p1_rdata  out  DATA_WIDTH  each; registered read result.
REQ-012 SHALL have ports: p0_err / p1_err  out  1  each; access rejected, valid with ack.
REQ-013 SHALL have ports: mem_w_en  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_rdata  in  DATA_WIDTH (combinational read, synchronous write memory).

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE; one transaction per 3 cycles maximum.
REQ-015 IDLE: if any req, SHALL pick winner, latch its we/addr/wdata and winner id into command registers, go ISSUE; else stay IDLE.
REQ-016 Arbitration SHALL be round-robin: single requester always wins; both requesting -> port holding priority wins.
REQ-017 Priority pointer SHALL move to the non-winning port in DONE; reset priority = port 0.
REQ-018 ISSUE: mem_addr/mem_wdata SHALL equal latched values; mem_w_en = latched we AND NOT rst AND NOT err, high only in ISSUE.
REQ-019 ISSUE, read: mem_rdata SHALL be captured into winner's rdata register at end of ISSUE; other port's rdata unchanged.
REQ-020 ISSUE, write: winner's rdata SHALL remain unchanged.
REQ-021 DONE: winner's ack SHALL be 1 for exactly that cycle; loser ack 0; next state IDLE.
REQ-022 Latency: req seen at edge E -> ISSUE cycle after E, ack high in cycle after E+1 edge, rdata valid same cycle as ack.
REQ-023 Requester SHALL hold req and fields until ack; request sampled in IDLE following DONE is a new transaction.
REQ-024 Req dropped after latching: latched transaction SHALL still complete and ack.
REQ-025 Outside ISSUE mem_addr/mem_wdata SHALL hold last latched values; mem_w_en = 0.
REQ-026 Address bits [1:0] SHALL pass unmodified; word selection is the memory's job.

Reset
REQ-027 rst high at an edge SHALL force state IDLE, priority port 0, command registers 0, all ack/err 0, p0_rdata/p1_rdata 0.
REQ-028 rst mid-transaction SHALL abort it without ack; rst in ISSUE SHALL suppress mem_w_en, so no write commits.
REQ-029 First arbitration after rst deasserts SHALL occur at the first edge with rst low.

Configuration
REQ-030 Macro DMEM_ARB_ADDR_CHECK_EN defined: IDLE SHALL flag latched request as error if addr[1:0] != 0 or addr >= MEM_DEPTH*4.
REQ-031 Errored request SHALL still pass ISSUE/DONE timing, write suppressed, rdata unchanged, err = 1 with ack for one cycle.
REQ-032 Macro undefined: no checking, p0_err/p1_err tied 0, all addresses forwarded.

Verification
REQ-033 Reset then p0 write addr 0x10 data 0xDEADBEEF -> mem_w_en 1 for one cycle in ISSUE, p0_ack pulse 2 cycles after request edge.
REQ-034 p1 read addr 0x10 after REQ-033 -> p1_rdata = 0xDEADBEEF with p1_ack; p0_rdata unchanged.
REQ-035 p0 and p1 request together continuously -> grants alternate p0, p1, p0, p1; acks every 3 cycles.
REQ-036 rst asserted in ISSUE of p1 write 0x55 to 0x20 -> no write, no ack; later read 0x20 returns prior value.
REQ-037 With DMEM_ARB_ADDR_CHECK_EN: p0 write addr 0x1000 (depth 1024) -> p0_err and p0_ack 1, mem_w_en stays 0; addr 0x0FFC succeeds.
REQ-038 Without macro: same 0x1000 write -> mem_w_en pulses, p0_err 0.
